// File: rtl/ibex_multdiv_iter_pkg.sv
// ibex_multdiv_iter_pkg: shared types and constants for the iterative multiply/divide unit.
// Provides the operator encoding, the iteration FSM states and the widest supported operand.
package ibex_multdiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        COMP  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } md_iter_state_e;

    localparam int unsigned MD_ITER_MAX_WIDTH = 64;

    // DIV and REM share the upper encoding bit
    function automatic logic md_op_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_negate.sv
// ibex_multdiv_iter_negate: conditional two's-complement negator.
// Produces -i_val when i_neg is set, i_val otherwise.
module ibex_multdiv_iter_negate #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] i_val,
    input  logic             i_neg,
    output logic [Width-1:0] o_val
);

    // Invert-and-increment when negation is requested, pass through otherwise
    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + {{(Width-1){1'b0}}, 1'b1};
        end else begin
            o_val = i_val;
        end
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter: iterative multiply/divide unit, one bit per cycle.
// Multiply is a signed shift-add over (Width+1)-bit extended operands into a 2*Width
// accumulator; divide is restoring long division on magnitudes with a sign fixup.
// Build macro IBEX_MULTDIV_ITER_EARLY_EXIT_EN: zero-operand multiplies finish in one
// cycle and divides skip the dividend's leading zeros; results are unchanged.
module ibex_multdiv_iter
    import ibex_multdiv_iter_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             kill_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(Width);

    md_iter_state_e     r_state, w_state_next;
    logic [CntW-1:0]    r_cnt;
    md_op_e             r_op;
    logic               r_sign_a, r_sign_b;
    logic [2*Width-1:0] r_mcand, r_acc;
    logic [Width-1:0]   r_mplier, r_quo, r_rem, r_divisor, r_result;
    logic               r_req_ready, r_res_valid, r_busy;

    logic               w_accept, w_in_is_div, w_in_b_zero, w_in_zero_mul;
    logic               w_a_sign, w_b_sign, w_q_bit, w_neg0_en;
    logic [Width-1:0]   w_imm_result, w_neg0_in, w_neg0_out, w_neg1_out;
    logic [Width-1:0]   w_dividend_abs;
    logic [CntW-1:0]    w_cnt_init;
    logic [2*Width-1:0] w_pp, w_acc_next;
    logic [Width:0]     w_rem_sh, w_diff;

    assign w_a_sign    = op_a_i[Width-1] & signed_mode_i[0];
    assign w_b_sign    = op_b_i[Width-1] & signed_mode_i[1];
    assign w_in_is_div = md_op_is_div(operator_i);
    assign w_in_b_zero = (op_b_i == {Width{1'b0}});
    assign w_accept    = req_valid_i & r_req_ready & ~kill_i;

`ifdef IBEX_MULTDIV_ITER_EARLY_EXIT_EN
    assign w_in_zero_mul = ~w_in_is_div & ((op_a_i == {Width{1'b0}}) | w_in_b_zero);
`else
    assign w_in_zero_mul = 1'b0;
`endif

    // Result for operations that hop straight from IDLE to DONE
    always_comb begin
        w_imm_result = {Width{1'b0}};
        if (w_in_is_div && w_in_b_zero) begin
            w_imm_result = (operator_i == MD_OP_DIV) ? {Width{1'b1}} : op_a_i;
        end else begin
            w_imm_result = {Width{1'b0}};
        end
    end

    // Partial product: the final multiplier bit carries negative weight when op_b is signed
    always_comb begin
        w_pp = {(2*Width){1'b0}};
        if (r_sign_b && (r_cnt == {CntW{1'b0}})) begin
            w_pp = ~r_mcand + {{(2*Width-1){1'b0}}, 1'b1};
        end else if (r_mplier[0]) begin
            w_pp = r_mcand;
        end else begin
            w_pp = {(2*Width){1'b0}};
        end
    end

    assign w_acc_next = r_acc + w_pp;

    // Restoring division step: shift in the next dividend bit, keep the difference if non-negative
    assign w_rem_sh = {r_rem, r_quo[Width-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};
    assign w_q_bit  = ~w_diff[Width];

    // Negator 0 takes the dividend in ABS and the selected quotient/remainder in FIXUP
    always_comb begin
        w_neg0_in = r_quo;
        w_neg0_en = r_sign_a;
        if (r_state == FIXUP) begin
            w_neg0_in = (r_op == MD_OP_DIV) ? r_quo : r_rem;
            w_neg0_en = (r_op == MD_OP_DIV) ? (r_sign_a ^ r_sign_b) : r_sign_a;
        end else begin
            w_neg0_in = r_quo;
            w_neg0_en = r_sign_a;
        end
    end

    ibex_multdiv_iter_negate #(.Width(Width)) u_negate_a (
        .i_val (w_neg0_in),
        .i_neg (w_neg0_en),
        .o_val (w_neg0_out)
    );

    ibex_multdiv_iter_negate #(.Width(Width)) u_negate_b (
        .i_val (r_divisor),
        .i_neg (r_sign_b),
        .o_val (w_neg1_out)
    );

`ifdef IBEX_MULTDIV_ITER_EARLY_EXIT_EN
    logic [CntW-1:0] w_lzc;

    // Leading-zero count of the dividend magnitude; zero counts as Width-1 so one iteration remains
    always_comb begin
        w_lzc = CntW'(Width - 1);
        for (int i = 0; i < Width; i++) begin
            w_lzc = w_neg0_out[i] ? CntW'(Width - 1 - i) : w_lzc;
        end
    end

    assign w_dividend_abs = w_neg0_out << w_lzc;
    assign w_cnt_init     = CntW'(Width - 1) - w_lzc;
`else
    assign w_dividend_abs = w_neg0_out;
    assign w_cnt_init     = CntW'(Width - 1);
`endif

    // Next-state logic; kill overrides everything outside IDLE
    always_comb begin
        w_state_next = r_state;
        if (kill_i && (r_state != IDLE)) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_accept) begin
                        w_state_next = IDLE;
                    end else if (!w_in_is_div) begin
                        w_state_next = w_in_zero_mul ? DONE : COMP;
                    end else if (w_in_b_zero) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ABS;
                    end
                end
                ABS:     w_state_next = COMP;
                COMP: begin
                    if (r_cnt == {CntW{1'b0}}) begin
                        w_state_next = md_op_is_div(r_op) ? FIXUP : DONE;
                    end else begin
                        w_state_next = COMP;
                    end
                end
                FIXUP:   w_state_next = DONE;
                DONE:    w_state_next = res_ready_i ? IDLE : DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register plus registered handshake and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == IDLE);
            r_res_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next != IDLE);
        end
    end

    // Operand capture, per-iteration datapath update and result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= {CntW{1'b0}};
            r_op      <= MD_OP_MULL;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_mcand   <= {(2*Width){1'b0}};
            r_acc     <= {(2*Width){1'b0}};
            r_mplier  <= {Width{1'b0}};
            r_quo     <= {Width{1'b0}};
            r_rem     <= {Width{1'b0}};
            r_divisor <= {Width{1'b0}};
            r_result  <= {Width{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= operator_i;
                        r_sign_a  <= w_a_sign;
                        r_sign_b  <= w_b_sign;
                        r_mcand   <= {{Width{w_a_sign}}, op_a_i};
                        r_acc     <= {(2*Width){1'b0}};
                        r_mplier  <= op_b_i;
                        r_quo     <= op_a_i;
                        r_rem     <= {Width{1'b0}};
                        r_divisor <= op_b_i;
                        r_cnt     <= CntW'(Width - 1);
                        r_result  <= w_imm_result;
                    end
                end
                ABS: begin
                    r_quo     <= w_dividend_abs;
                    r_divisor <= w_neg1_out;
                    r_cnt     <= w_cnt_init;
                end
                COMP: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_q_bit ? w_diff[Width-1:0] : w_rem_sh[Width-1:0];
                    r_quo    <= {r_quo[Width-2:0], w_q_bit};
                    r_cnt    <= r_cnt - {{(CntW-1){1'b0}}, 1'b1};
                    if ((r_cnt == {CntW{1'b0}}) && !md_op_is_div(r_op)) begin
                        r_result <= (r_op == MD_OP_MULL) ? w_acc_next[Width-1:0]
                                                         : w_acc_next[2*Width-1:Width];
                    end
                end
                FIXUP: begin
                    r_result <= w_neg0_out;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign res_valid_o = r_res_valid;
    assign busy_o      = r_busy;
    assign result_o    = r_result;

endmodule
